// File: rtl/alu_pkg.sv
// alu_pkg: shared command codes, ALU op encodings and decoded control bundle.
package alu_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  typedef enum logic [3:0] {
    CMD_ADD  = 4'd0,
    CMD_SUB  = 4'd1,
    CMD_XOR  = 4'd2,
    CMD_ANDN = 4'd3,
    CMD_ROL  = 4'd4,
    CMD_SLL  = 4'd5,
    CMD_ROR  = 4'd6,
    CMD_SRL  = 4'd7,
    CMD_SEQ  = 4'd8,
    CMD_SLT  = 4'd9,
    CMD_SLE  = 4'd10,
    CMD_SCO  = 4'd11
  } cmd_e;
  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;
  typedef struct packed {
    logic [2:0] op;
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic       sign;
    logic       is_set;
    logic       legal;
  } ctl_t;
endpackage

// File: rtl/alu_cmd_decode.sv
// alu_cmd_decode: command code to ALU controls. Ports: cmd (4-bit code) in, ctl (op/inv/cin/sign/is_set/legal) out.
module alu_cmd_decode
  import alu_pkg::*;
(
  input  logic [3:0] cmd,
  output ctl_t       ctl
);
  always_comb begin
    ctl = '0;
    ctl.legal = 1'b1;
    case (cmd)
      CMD_ADD:  begin ctl.op = OP_ADD; ctl.sign = 1'b1; end
      CMD_SUB:  begin ctl.op = OP_ADD; ctl.inv_a = 1'b1; ctl.cin = 1'b1; ctl.sign = 1'b1; end
      CMD_XOR:  ctl.op = OP_XOR;
      CMD_ANDN: begin ctl.op = OP_AND; ctl.inv_b = 1'b1; end
      CMD_ROL:  ctl.op = OP_ROL;
      CMD_SLL:  ctl.op = OP_SLL;
      CMD_ROR:  ctl.op = OP_ROR;
      CMD_SRL:  ctl.op = OP_SRL;
      CMD_SEQ, CMD_SLT, CMD_SLE: begin
        ctl.op = OP_ADD;
        ctl.inv_b = 1'b1;
        ctl.cin = 1'b1;
        ctl.sign = 1'b1;
        ctl.is_set = 1'b1;
      end
      CMD_SCO:  begin ctl.op = OP_ADD; ctl.is_set = 1'b1; end
      default:  ctl.legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-stage ALU driver. Ports: cmd_* valid/ready command in, alu_* registered ALU controls out, alu_out/ofl/Z in, res_* valid/ready result out.
module alu_issue_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  output logic             alu_invA,
  output logic             alu_invB,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ofl,
  input  logic             alu_Z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ofl,
  output logic             res_z,
  output logic             res_err
);
  import alu_pkg::*;
  ctl_t ctl;
  logic e1_valid, e1_set, e1_legal, e2_free, acc, adv, lt, set_bit;
  logic [3:0] e1_cmd;
  logic [WIDTH-1:0] nxt;
  alu_cmd_decode u_dec (.cmd(cmd_op), .ctl(ctl));
  assign e2_free = !res_valid || res_ready;
  // Gated by rst so every output reads 0 while reset is held.
  assign cmd_ready = !rst && (!e1_valid || e2_free);
  assign acc = cmd_valid && cmd_ready;
  assign adv = e1_valid && e2_free;
  assign lt = alu_out[WIDTH-1] ^ alu_ofl;
  assign set_bit = e1_cmd == CMD_SEQ ? alu_Z :
                   e1_cmd == CMD_SLT ? lt :
                   e1_cmd == CMD_SLE ? (lt | alu_Z) : alu_ofl;
  assign nxt = !e1_legal ? '0 : e1_set ? WIDTH'(set_bit) : alu_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid <= 1'b0;
      e1_cmd <= '0;
      e1_set <= 1'b0;
      e1_legal <= 1'b0;
      alu_A <= '0;
      alu_B <= '0;
      alu_op <= '0;
      alu_invA <= 1'b0;
      alu_invB <= 1'b0;
      alu_cin <= 1'b0;
      alu_sign <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_ofl <= 1'b0;
      res_z <= 1'b0;
      res_err <= 1'b0;
    end else begin
      if (acc) begin
        e1_valid <= 1'b1;
        e1_cmd <= cmd_op;
        e1_set <= ctl.is_set;
        e1_legal <= ctl.legal;
        alu_A <= ctl.legal ? cmd_a : '0;
        // Shifter ops only see the count bits of B.
        alu_B <= !ctl.legal ? '0 : ctl.op[2] ? cmd_b : WIDTH'(cmd_b[CNT_W-1:0]);
        alu_op <= ctl.op;
        alu_invA <= ctl.inv_a;
        alu_invB <= ctl.inv_b;
        alu_cin <= ctl.cin;
        alu_sign <= ctl.sign;
      end else if (adv) begin
        e1_valid <= 1'b0;
        alu_A <= '0;
        alu_B <= '0;
        alu_op <= '0;
        alu_invA <= 1'b0;
        alu_invB <= 1'b0;
        alu_cin <= 1'b0;
        alu_sign <= 1'b0;
      end
      if (adv) begin
        res_valid <= 1'b1;
        res_data <= nxt;
        res_ofl <= (e1_cmd == CMD_ADD || e1_cmd == CMD_SUB) && alu_ofl;
        res_z <= nxt == '0;
        res_err <= !e1_legal;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a behavioural 16-bit ALU closing the loop.
module tb_alu_issue_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, res_ready = 1'b0;
  logic cmd_ready, res_valid, res_ofl, res_z, res_err;
  logic [3:0] cmd_op = '0;
  logic [15:0] cmd_a = '0, cmd_b = '0, res_data;
  logic [15:0] alu_A, alu_B, alu_out;
  logic [2:0] alu_op;
  logic alu_cin, alu_invA, alu_invB, alu_sign, alu_ofl, alu_Z;
  logic [15:0] aa, bb;
  logic [16:0] sum;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_A(alu_A), .alu_B(alu_B), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_Z(alu_Z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ofl(res_ofl), .res_z(res_z), .res_err(res_err)
  );
  always_comb begin
    aa = alu_invA ? ~alu_A : alu_A;
    bb = alu_invB ? ~alu_B : alu_B;
    sum = {1'b0, aa} + {1'b0, bb} + 17'(alu_cin);
    alu_ofl = 1'b0;
    case (alu_op)
      3'b000: alu_out = (alu_A << alu_B[3:0]) | (alu_A >> (16 - int'(alu_B[3:0])));
      3'b001: alu_out = alu_A << alu_B[3:0];
      3'b010: alu_out = (alu_A >> alu_B[3:0]) | (alu_A << (16 - int'(alu_B[3:0])));
      3'b011: alu_out = alu_A >> alu_B[3:0];
      3'b100: begin
        alu_out = sum[15:0];
        alu_ofl = alu_sign ? (aa[15] == bb[15] && sum[15] != aa[15]) : sum[16];
      end
      3'b101: alu_out = aa | bb;
      3'b110: alu_out = aa ^ bb;
      default: alu_out = aa & bb;
    endcase
    alu_Z = alu_out == 16'h0;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    n_chk++; if (alu_A !== 16'h0 || alu_op !== 3'b000) begin n_fail++; $display("FAIL reset_alu got A=%h op=%b exp 0", alu_A, alu_op); end
    n_chk++; if (res_data !== 16'h0 || res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res got data=%h err=%b exp 0", res_data, res_err); end
    rst = 1'b0;
    #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cmd_ready got %b exp 1", cmd_ready); end
  endtask
  task automatic test_add;
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'h7FFF; cmd_b = 16'h0001;
    tick;
    cmd_valid = 1'b0;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid got %b exp 0", res_valid); end
    n_chk++; if (alu_A !== 16'h7FFF || alu_op !== 3'b100 || alu_sign !== 1'b1) begin n_fail++; $display("FAIL add_alu got A=%h op=%b sign=%b exp 7fff 100 1", alu_A, alu_op, alu_sign); end
    tick;
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b exp 1", res_valid); end
    n_chk++; if (res_data !== 16'h8000) begin n_fail++; $display("FAIL add_data got %h exp 8000", res_data); end
    n_chk++; if ({res_ofl, res_z, res_err} !== 3'b100) begin n_fail++; $display("FAIL add_flags got ofl/z/err=%b exp 100", {res_ofl, res_z, res_err}); end
    tick;
    n_chk++; if (res_valid !== 1'b0 || alu_A !== 16'h0) begin n_fail++; $display("FAIL add_drain got valid=%b A=%h exp 0 0000", res_valid, alu_A); end
  endtask
  task automatic test_sub;
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 16'h0003; cmd_b = 16'h0003;
    tick;
    cmd_valid = 1'b0;
    n_chk++; if ({alu_invA, alu_invB, alu_cin} !== 3'b101) begin n_fail++; $display("FAIL sub_ctl got invA/invB/cin=%b exp 101", {alu_invA, alu_invB, alu_cin}); end
    tick;
    n_chk++; if (res_data !== 16'h0 || res_z !== 1'b1 || res_ofl !== 1'b0) begin n_fail++; $display("FAIL sub_res got data=%h z=%b ofl=%b exp 0000 1 0", res_data, res_z, res_ofl); end
  endtask
  task automatic test_set;
    cmd_valid = 1'b1; cmd_op = 4'd9; cmd_a = 16'h8000; cmd_b = 16'h0001;
    tick;
    cmd_op = 4'd10; cmd_a = 16'h0005; cmd_b = 16'h0005;
    tick;
    n_chk++; if (res_valid !== 1'b1 || res_data !== 16'h0001 || res_ofl !== 1'b0) begin n_fail++; $display("FAIL slt got valid=%b data=%h ofl=%b exp 1 0001 0", res_valid, res_data, res_ofl); end
    cmd_op = 4'd11; cmd_a = 16'hFFFF; cmd_b = 16'h0001;
    tick;
    cmd_valid = 1'b0;
    n_chk++; if (res_data !== 16'h0001 || res_z !== 1'b0) begin n_fail++; $display("FAIL sle got data=%h z=%b exp 0001 0", res_data, res_z); end
    n_chk++; if (alu_sign !== 1'b0 || alu_op !== 3'b100) begin n_fail++; $display("FAIL sco_ctl got sign=%b op=%b exp 0 100", alu_sign, alu_op); end
    tick;
    n_chk++; if (res_data !== 16'h0001 || res_ofl !== 1'b0) begin n_fail++; $display("FAIL sco got data=%h ofl=%b exp 0001 0", res_data, res_ofl); end
  endtask
  task automatic test_shift;
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_a = 16'h0001; cmd_b = 16'h000F;
    tick;
    cmd_valid = 1'b0;
    n_chk++; if (alu_op !== 3'b001 || alu_B !== 16'h000F) begin n_fail++; $display("FAIL sll_ctl got op=%b B=%h exp 001 000f", alu_op, alu_B); end
    tick;
    n_chk++; if (res_data !== 16'h8000) begin n_fail++; $display("FAIL sll_data got %h exp 8000", res_data); end
  endtask
  task automatic test_back_to_back;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'h0001; cmd_b = 16'h0002;
    tick;
    cmd_op = 4'd2; cmd_a = 16'hF0F0; cmd_b = 16'h0FF0;
    tick;
    n_chk++; if (res_valid !== 1'b1 || res_data !== 16'h0003) begin n_fail++; $display("FAIL b2b_r0 got valid=%b data=%h exp 1 0003", res_valid, res_data); end
    res_ready = 1'b0;
    cmd_op = 4'd3; cmd_a = 16'h1234; cmd_b = 16'h00FF;
    #1;
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_cmd_ready got %b exp 0", cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++; if (res_valid !== 1'b1 || res_data !== 16'h0003) begin n_fail++; $display("FAIL b2b_stall_res%0d got valid=%b data=%h exp 1 0003", i, res_valid, res_data); end
      n_chk++; if (alu_A !== 16'hF0F0 || alu_op !== 3'b110 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_alu%0d got A=%h op=%b rdy=%b exp f0f0 110 0", i, alu_A, alu_op, cmd_ready); end
    end
    res_ready = 1'b1;
    tick;
    n_chk++; if (res_data !== 16'hFF00) begin n_fail++; $display("FAIL b2b_r1 got %h exp ff00", res_data); end
    cmd_op = 4'd7; cmd_a = 16'h8000; cmd_b = 16'h0004;
    tick;
    cmd_valid = 1'b0;
    n_chk++; if (res_data !== 16'h1200) begin n_fail++; $display("FAIL b2b_r2 got %h exp 1200", res_data); end
    tick;
    n_chk++; if (res_valid !== 1'b1 || res_data !== 16'h0800) begin n_fail++; $display("FAIL b2b_r3 got valid=%b data=%h exp 1 0800", res_valid, res_data); end
    tick;
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %b exp 0", res_valid); end
  endtask
  task automatic test_illegal_reset;
    cmd_valid = 1'b1; cmd_op = 4'hE; cmd_a = 16'h0005; cmd_b = 16'h0007;
    tick;
    n_chk++; if (alu_A !== 16'h0 || alu_B !== 16'h0 || alu_op !== 3'b000) begin n_fail++; $display("FAIL ill_alu got A=%h B=%h op=%b exp 0", alu_A, alu_B, alu_op); end
    cmd_op = 4'd0; cmd_a = 16'h0001; cmd_b = 16'h0001;
    tick;
    cmd_valid = 1'b0;
    n_chk++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 16'h0 || res_z !== 1'b1) begin n_fail++; $display("FAIL ill_res got valid=%b err=%b data=%h z=%b exp 1 1 0000 1", res_valid, res_err, res_data, res_z); end
    n_chk++; if (alu_A !== 16'h0001) begin n_fail++; $display("FAIL ill_e1_loaded got A=%h exp 0001", alu_A); end
    rst = 1'b1;
    tick;
    n_chk++; if (res_valid !== 1'b0 || res_err !== 1'b0 || alu_A !== 16'h0 || alu_sign !== 1'b0) begin n_fail++; $display("FAIL rst_flush got valid=%b err=%b A=%h sign=%b exp 0", res_valid, res_err, alu_A, alu_sign); end
    rst = 1'b0;
    tick;
    tick;
    n_chk++; if (res_valid !== 1'b0 || res_data !== 16'h0 || alu_A !== 16'h0) begin n_fail++; $display("FAIL rst_stale got valid=%b data=%h A=%h exp 0", res_valid, res_data, alu_A); end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_set;
    test_shift;
    test_back_to_back;
    test_illegal_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
